// File: rtl/alu_ctrl_pkg.sv
// Purpose : shared funct codes, HiLo output-enable code and sequencer state type
//           for the ALU control path (ALU, shifter, multiplier, result mux).
// Latency : n/a (declarations only).  Backpressure: n/a.
// Ports   : none (package).
package alu_ctrl_pkg;

  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_NOP   = 6'h00;

  // Drives the result mux to the HiLo write-back path.
  localparam logic [5:0] HILO_OE = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Ops that touch the multiplier or HiLo and so conflict with a multiply in flight.
  function automatic logic is_hilo_op(input logic [5:0] f);
    return (f == F_MULTU) || (f == F_MFHI) || (f == F_MFLO);
  endfunction

endpackage

// File: rtl/mult_step_counter.sv
// Purpose : loadable up-counter with terminal-count flag for iterative units.
// Latency : count visible one cycle after each enabled edge; tc is combinational.
// Backpressure: none; counts whenever en is high.
// Ports   : clk, rst_n (async active-low), clr (sync clear), en (count),
//           cnt (current count), tc (cnt == MUL_CYCLES-1).
module mult_step_counter #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  assign tc = (cnt == CNT_W'(MUL_CYCLES - 1));

  // Terminal count returns to zero rather than wrapping, so cnt never
  // exceeds MUL_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (en && tc)) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Purpose : registers the ALU function code and sequences MULTU load/step/HiLo write-back.
// Latency : sig_out one cycle after issue; MULTU busy for MUL_CYCLES+2 cycles.
// Backpressure: combinational stall holds MULTU/MFHI/MFLO during a multiply, all ops in WB.
// Ports   : clk, rst_n (async active-low), op_valid/funct (issue), sig_out (registered
//           control code), mul_load/mul_step/hilo_we (multiplier/HiLo strobes),
//           stall (upstream hold), busy (multiply in progress), step_cnt (debug).
module mult_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  output logic [5:0]       sig_out,
  output logic             mul_load,
  output logic             mul_step,
  output logic             hilo_we,
  output logic             stall,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt
);

  state_t state;
  state_t state_nxt;
  logic   last_step;

  // Non-HiLo ops may overlap a multiply; WB owns sig_out so everything waits there.
  assign stall = op_valid && (state != ST_IDLE) &&
                 (is_hilo_op(funct) || (state == ST_WB));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (op_valid && (funct == F_MULTU)) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobes decoded from the registered state only, so they are glitch-free.
  always_comb begin
    mul_load = (state == ST_LOAD);
    mul_step = (state == ST_RUN);
    hilo_we  = (state == ST_WB);
    busy     = (state != ST_IDLE);
  end

  // sig_out is loaded with HILO_OE on the edge entering WB so it lines up with hilo_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_out <= F_NOP;
    end else if (state_nxt == ST_WB) begin
      sig_out <= HILO_OE;
    end else if (op_valid && !stall) begin
      sig_out <= funct;
    end else begin
      sig_out <= F_NOP;
    end
  end

  mult_step_counter #(
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_RUN),
    .en    (state == ST_RUN),
    .cnt   (step_cnt),
    .tc    (last_step)
  );

endmodule

// File: tb/tb_mult_sequencer.sv
// Purpose : self-checking bench for mult_sequencer against a cycle-offset reference model.
// Latency : n/a.  Backpressure: bench holds op_valid/funct while stall is high.
// Ports   : none (top-level bench).
module tb_mult_sequencer;

  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             op_valid;
  logic [5:0]       funct;
  logic [5:0]       sig_out;
  logic             mul_load;
  logic             mul_step;
  logic             hilo_we;
  logic             stall;
  logic             busy;
  logic [CNT_W-1:0] step_cnt;

  always #5 clk = ~clk;

  mult_sequencer #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .funct    (funct),
    .sig_out  (sig_out),
    .mul_load (mul_load),
    .mul_step (mul_step),
    .hilo_we  (hilo_we),
    .stall    (stall),
    .busy     (busy),
    .step_cnt (step_cnt)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: m is the number of cycles since a MULTU was accepted
  // (-1 = no multiply). 0 = load, 1..MUL_CYCLES = steps, MUL_CYCLES+1 = write-back.
  int         m       = -1;
  logic [5:0] exp_sig = 6'h00;
  bit         last_stall;
  int         busy_seen, step_seen, load_seen, we_seen;

  function automatic bit hazard_op(input logic [5:0] f);
    return (f == 6'h19) || (f == 6'h10) || (f == 6'h12);
  endfunction

  function automatic bit model_stall();
    return op_valid && (m >= 0) && (hazard_op(funct) || (m == MUL_CYCLES + 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("sig_out",  32'(sig_out),  32'(exp_sig));
    chk("mul_load", 32'(mul_load), 32'(m == 0));
    chk("mul_step", 32'(mul_step), 32'(m >= 1 && m <= MUL_CYCLES));
    chk("hilo_we",  32'(hilo_we),  32'(m == MUL_CYCLES + 1));
    chk("busy",     32'(busy),     32'(m >= 0));
    chk("step_cnt", 32'(step_cnt), (m >= 1 && m <= MUL_CYCLES) ? 32'(m - 1) : 32'd0);
    chk("stall",    32'(stall),    32'(model_stall()));
  endtask

  // One clock: check mid-cycle, then advance the model across the rising edge.
  task automatic tick();
    bit st;
    @(negedge clk);
    check_outputs();
    busy_seen += int'(busy);
    step_seen += int'(mul_step);
    load_seen += int'(mul_load);
    we_seen   += int'(hilo_we);
    st = model_stall();
    last_stall = st;
    @(posedge clk);
    if (!rst_n) begin
      m = -1;
      exp_sig = 6'h00;
    end else begin
      if (m == MUL_CYCLES) exp_sig = 6'h3F;
      else if (op_valid && !st) exp_sig = funct;
      else exp_sig = 6'h00;
      if (m == MUL_CYCLES + 1) m = -1;
      else if (m >= 0) m++;
      else if (op_valid && funct == 6'h19) m = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_seen();
    busy_seen = 0; step_seen = 0; load_seen = 0; we_seen = 0;
  endtask

  initial begin
    logic [5:0] op_tab [10];
    op_tab = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h00, 6'h19, 6'h10, 6'h12, 6'h3B};

    rst_n = 1'b0; op_valid = 1'b0; funct = 6'h00;
    #1;
    // Reset state and idle ALU op.
    repeat (3) tick();
    rst_n = 1'b1;
    op_valid = 1'b1; funct = 6'h20; tick();
    op_valid = 1'b0; funct = 6'h00; tick(); tick();

    // Full MULTU sequence with pulse-length accounting.
    clear_seen();
    op_valid = 1'b1; funct = 6'h19; tick();
    op_valid = 1'b0; repeat (MUL_CYCLES + 4) tick();
    chk("load_len", 32'(load_seen), 32'd1);
    chk("step_len", 32'(step_seen), 32'(MUL_CYCLES));
    chk("we_len",   32'(we_seen),   32'd1);
    chk("busy_len", 32'(busy_seen), 32'(MUL_CYCLES + 2));

    // HiLo hazard: MFHI presented 5 cycles in and held until accepted.
    op_valid = 1'b1; funct = 6'h19; tick();
    op_valid = 1'b0; repeat (4) tick();
    op_valid = 1'b1; funct = 6'h10;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!last_stall) break;
    end
    chk("mfhi_accepted", 32'(last_stall), 32'd0);
    op_valid = 1'b0; repeat (2) tick();

    // Overlap: OR then SLT issued during RUN.
    op_valid = 1'b1; funct = 6'h19; tick();
    op_valid = 1'b0; repeat (5) tick();
    op_valid = 1'b1; funct = 6'h25; tick();
    funct = 6'h2A; tick();
    op_valid = 1'b0; repeat (MUL_CYCLES) tick();

    // Back-to-back: second MULTU held from RUN onward.
    clear_seen();
    op_valid = 1'b1; funct = 6'h19; tick();
    op_valid = 1'b0; repeat (3) tick();
    op_valid = 1'b1; funct = 6'h19;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!last_stall) break;
    end
    op_valid = 1'b0; repeat (MUL_CYCLES + 4) tick();
    chk("b2b_loads", 32'(load_seen), 32'd2);
    chk("b2b_writes", 32'(we_seen), 32'd2);

    // Mid-op reset at step_cnt == 17.
    clear_seen();
    op_valid = 1'b1; funct = 6'h19; tick();
    op_valid = 1'b0;
    for (int i = 0; i < 60 && m != 18; i++) tick();
    chk("pre_reset_cnt", 32'(step_cnt), 32'd17);
    #2 rst_n = 1'b0;
    #1;
    m = -1; exp_sig = 6'h00;
    check_outputs();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("no_we_after_reset", 32'(we_seen), 32'd0);
    op_valid = 1'b1; funct = 6'h19; tick();
    op_valid = 1'b0; repeat (MUL_CYCLES + 4) tick();

    // Randomized traffic; stalled ops are held as upstream would.
    last_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        int k;
        op_valid = 1'($urandom_range(0, 1));
        k = int'($urandom_range(0, 9));
        funct = (k == 9) ? 6'($urandom) : op_tab[k];
      end
      tick();
    end
    op_valid = 1'b0;
    repeat (MUL_CYCLES + 4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
